// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch state encoding and NOP encoding
package cpu_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam logic [31:0] NOP_INST         = 32'h03400000;  // andi r0,r0,0

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction SRAM, redirect and decode handshake bundle
interface inst_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [INST_W-1:0] inst_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_adef;

    modport master (
        output inst_req, inst_addr, id_valid, id_pc, id_inst, id_adef,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  inst_req, inst_addr, id_valid, id_pc, id_inst, id_adef,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding fetch FSM with redirect squash; FETCH_ADEF_CHECK_EN enables misaligned-PC fault
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch_unit_if.master     bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              cancel_q, cancel_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_adef_q, id_adef_d;
    logic              misaligned;
    logic              req_accepted;

`ifdef FETCH_ADEF_CHECK_EN
    assign misaligned    = (pc_q[1:0] != 2'b00);
    assign bus.inst_addr = pc_q;
`else
    assign misaligned    = 1'b0;
    assign bus.inst_addr = {pc_q[ADDR_W-1:2], 2'b00};
`endif

    // A misaligned PC never reaches the bus, so addr_ok cannot accept it.
    assign req_accepted = bus.inst_addr_ok && !misaligned;

    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_adef  = id_adef_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            cancel_q   <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_adef_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cancel_q   <= cancel_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_adef_q  <= id_adef_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cancel_d     = cancel_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        id_adef_d    = id_adef_q;
        bus.inst_req = 1'b0;

        case (state_q)
            S_REQ: begin
                bus.inst_req = !reset && !misaligned;
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    if (req_accepted) begin
                        // Accepted request now targets a stale PC; squash its data.
                        cancel_d = 1'b1;
                        state_d  = S_WAIT;
                    end
                end else if (misaligned) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_q;
                    id_inst_d  = NOP_INST;
                    id_adef_d  = 1'b1;
                    state_d    = S_HOLD;
                end else if (req_accepted) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    if (bus.inst_data_ok) begin
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        cancel_d = 1'b1;
                    end
                end else if (bus.inst_data_ok) begin
                    if (cancel_q) begin
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_q;
                        id_inst_d  = bus.inst_rdata;
                        id_adef_d  = 1'b0;
                        state_d    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // Redirect takes priority over the sequential +4.
                if (bus.redirect_valid) begin
                    id_valid_d = 1'b0;
                    pc_d       = bus.redirect_pc;
                    state_d    = S_REQ;
                end else if (bus.id_ready) begin
                    id_valid_d = 1'b0;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    inst_fetch_unit_if #(.ADDR_W(32)) bus ();

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h1c000000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        bus.inst_addr_ok   = 1'b0;
        bus.inst_data_ok   = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
    endtask

    // Issue from S_REQ: addr_ok with req, data_ok one cycle later; ends in S_HOLD.
    task automatic fetch(input logic [31:0] word);
        bus.inst_addr_ok = 1'b1;
        tick();
        idle_inputs();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = word;
        tick();
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("reset_inst_req", 32'(bus.inst_req), 32'h0);
        check("reset_id_valid", 32'(bus.id_valid), 32'h0);
        check("reset_id_pc",    bus.id_pc,         32'h0);
        check("reset_id_inst",  bus.id_inst,       32'h0);
        check("reset_id_adef",  32'(bus.id_adef),  32'h0);

        reset = 1'b0;
        #1;
        check("first_req",  32'(bus.inst_req), 32'h1);
        check("first_addr", bus.inst_addr,     32'h1c000000);

        // Best-case fetch: id_valid two cycles after req
        bus.inst_addr_ok = 1'b1;
        tick();
        idle_inputs();
        check("wait_no_req", 32'(bus.inst_req), 32'h0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h02800421;
        tick();
        idle_inputs();
        check("hold_valid", 32'(bus.id_valid), 32'h1);
        check("hold_pc",    bus.id_pc,         32'h1c000000);
        check("hold_inst",  bus.id_inst,       32'h02800421);

        // Stall decode: outputs stable, no request
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(bus.id_valid), 32'h1);
            check("stall_pc",    bus.id_pc,         32'h1c000000);
            check("stall_inst",  bus.id_inst,       32'h02800421);
            check("stall_req",   32'(bus.inst_req), 32'h0);
        end
        bus.id_ready = 1'b1;
        tick();
        idle_inputs();
        check("seq_valid", 32'(bus.id_valid), 32'h0);
        check("seq_req",   32'(bus.inst_req), 32'h1);
        check("seq_addr",  bus.inst_addr,     32'h1c000004);

        // Redirect while waiting: returned word dropped
        bus.inst_addr_ok = 1'b1;
        tick();
        idle_inputs();
        redirect(32'h1c000100);
        tick();
        idle_inputs();
        check("wait_redir_req", 32'(bus.inst_req), 32'h0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hdeadbeef;
        tick();
        idle_inputs();
        check("drop_valid", 32'(bus.id_valid), 32'h0);
        check("drop_req",   32'(bus.inst_req), 32'h1);
        check("drop_addr",  bus.inst_addr,     32'h1c000100);

        // Redirect with addr_ok: next data_ok discarded, fresh request at target
        redirect(32'h1c000200);
        bus.inst_addr_ok = 1'b1;
        tick();
        idle_inputs();
        check("cancel_req", 32'(bus.inst_req), 32'h0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h11111111;
        tick();
        idle_inputs();
        check("cancel_valid", 32'(bus.id_valid), 32'h0);
        check("cancel_addr",  bus.inst_addr,     32'h1c000200);
        fetch(32'h02c00000);
        check("after_cancel_pc",   bus.id_pc,   32'h1c000200);
        check("after_cancel_inst", bus.id_inst, 32'h02c00000);
        bus.id_ready = 1'b1;
        tick();
        idle_inputs();
        check("inc_addr", bus.inst_addr, 32'h1c000204);

        // Redirect before acceptance changes the address in place
        redirect(32'h1c000008);
        tick();
        idle_inputs();
        check("req_redir_req",  32'(bus.inst_req), 32'h1);
        check("req_redir_addr", bus.inst_addr,     32'h1c000008);
        fetch(32'h02800c63);
        check("hold8_pc", bus.id_pc, 32'h1c000008);

        // Redirect beats +4 in S_HOLD
        bus.id_ready = 1'b1;
        redirect(32'h1c000040);
        tick();
        idle_inputs();
        check("hold_redir_valid", 32'(bus.id_valid), 32'h0);
        check("hold_redir_addr",  bus.inst_addr,     32'h1c000040);

        // Stray data_ok in S_REQ is ignored
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h22222222;
        tick();
        idle_inputs();
        check("stray_valid", 32'(bus.id_valid), 32'h0);
        check("stray_req",   32'(bus.inst_req), 32'h1);
        check("stray_addr",  bus.inst_addr,     32'h1c000040);

        // PC wrap
        redirect(32'hfffffffc);
        tick();
        idle_inputs();
        fetch(32'h03400000);
        check("wrap_hold_pc", bus.id_pc, 32'hfffffffc);
        bus.id_ready = 1'b1;
        tick();
        idle_inputs();
        check("wrap_addr", bus.inst_addr, 32'h00000000);

        // Misaligned redirect target
        redirect(32'h1c000002);
        tick();
        idle_inputs();
`ifdef FETCH_ADEF_CHECK_EN
        check("adef_no_req", 32'(bus.inst_req), 32'h0);
        tick();
        check("adef_valid", 32'(bus.id_valid), 32'h1);
        check("adef_flag",  32'(bus.id_adef),  32'h1);
        check("adef_inst",  bus.id_inst,       32'h03400000);
        check("adef_pc",    bus.id_pc,         32'h1c000002);
`else
        check("mis_req",  32'(bus.inst_req), 32'h1);
        check("mis_addr", bus.inst_addr,     32'h1c000000);
        fetch(32'h02801084);
        check("mis_pc",   bus.id_pc,         32'h1c000002);
        check("mis_adef", 32'(bus.id_adef),  32'h0);
`endif
        bus.id_ready = 1'b1;
        tick();
        idle_inputs();

        // Reset mid-request; late data_ok after reset is ignored
        redirect(32'h1c000300);
        tick();
        idle_inputs();
        bus.inst_addr_ok = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_req",  32'(bus.inst_req), 32'h1);
        check("rst_mid_addr", bus.inst_addr,     32'h1c000000);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h33333333;
        tick();
        idle_inputs();
        check("late_valid", 32'(bus.id_valid), 32'h0);
        check("late_req",   32'(bus.inst_req), 32'h1);
        check("late_addr",  bus.inst_addr,     32'h1c000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage feeding the multi-cycle LoongArch decode/execute FSM.
- Owns the architectural PC and issues one instruction-SRAM request at a time over an addr_ok/data_ok handshake.
- Holds the returned word for decode under a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and squashes any request already in flight.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_req  out  1  fetch request valid.
- inst_addr  out  ADDR_W  fetch address; equals pc while inst_req is high.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: branch taken / jump, load new PC.
- redirect_pc  in  ADDR_W  redirect target.
- id_valid  out  1  id_inst / id_pc valid for decode.
- id_ready  in  1  decode accepts the held instruction.
- id_pc  out  ADDR_W  PC of the held instruction.
- id_inst  out  32  held instruction word.
- id_adef  out  1  address-error flag on the held instruction (see Optional Feature).

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values:
  - pc=RESET_PC, state=S_REQ, cancel=0.
  - id_valid=0, id_pc=0, id_inst=0, id_adef=0.
  - inst_req is combinational from state: 0 while reset is high, 1 in the first cycle after reset falls.
- States:
  - S_REQ: inst_req=1, inst_addr=pc.
  - S_WAIT: request outstanding, inst_req=0.
  - S_HOLD: id_valid=1.
- S_REQ:
  - addr_ok=1 -> S_WAIT.
  - redirect without addr_ok -> pc<=redirect_pc, stay in S_REQ. The address may change because the request was not accepted.
  - redirect with addr_ok -> pc<=redirect_pc, cancel<=1, -> S_WAIT.
- S_WAIT:
  - data_ok with cancel=0 and no redirect -> id_inst<=rdata, id_pc<=pc, id_valid<=1, -> S_HOLD.
  - data_ok with cancel=1 -> drop data, cancel<=0, -> S_REQ.
  - redirect without data_ok -> pc<=redirect_pc, cancel<=1, stay in S_WAIT.
  - redirect with data_ok -> drop data, pc<=redirect_pc, cancel<=0, -> S_REQ.
- S_HOLD:
  - id_ready -> id_valid<=0, pc<=pc+4 (mod 2^ADDR_W), -> S_REQ.
  - redirect with or without id_ready -> handshake (if any) completes, id_valid<=0, pc<=redirect_pc, -> S_REQ. Redirect wins over the +4 increment.
  - Outputs stay stable while id_valid=1 && !id_ready.
- Outstanding limit: at most one outstanding request. data_ok outside S_WAIT is ignored.
- Best-case latency: addr_ok in the same cycle as req, data_ok the next cycle -> id_valid rises 2 cycles after req.
- id_ready in the same cycle as id_valid gives a back-to-back fetch with one cycle of inst_req per instruction.
- pc wraps 0xfffffffc -> 0x00000000 with no flag.
- Reset mid-request abandons the transaction. A late data_ok after reset lands in S_REQ and is ignored.

Optional Feature:
- Macro: FETCH_ADEF_CHECK_EN.
- Defined:
  - In S_REQ, pc[1:0]!=0 suppresses inst_req.
  - The next cycle goes directly to S_HOLD with id_pc=pc, id_inst=32'h03400000 (NOP, andi r0,r0,0), id_adef=1.
  - Redirect and ready rules are as in S_HOLD.
- Undefined:
  - id_adef is tied to 0.
  - inst_addr = {pc[ADDR_W-1:2],2'b00}.
  - pc[1:0] is ignored.

Decomposition:
- Shared package cpu_pkg:
  - state encoding (S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2).
  - RESET_PC default.
  - NOP_INST=32'h03400000.
  - INST_W=32.
- No sub-module; single FSM plus PC and hold registers.

Test Plan:
- Reset then addr_ok=1 with req, data_ok+rdata=32'h02800421 one cycle later, id_ready=1 -> id_pc=0x1c000000, id_inst=0x02800421; next inst_addr=0x1c000004.
- id_ready=0 for 5 cycles in S_HOLD -> id_valid, id_pc, id_inst stable, inst_req=0, no pc increment.
- Redirect to 0x1c000100 in S_WAIT, then data_ok with 0xdeadbeef -> word dropped, id_valid stays 0, next inst_addr=0x1c000100.
- Redirect together with addr_ok in S_REQ -> following data_ok is discarded, then a fresh request to redirect_pc.
- S_HOLD at pc 0x1c000008 with id_ready=1 and redirect to 0x1c000040 -> next inst_addr=0x1c000040, not 0x1c00000c.
- FETCH_ADEF_CHECK_EN defined, redirect to 0x1c000002 -> no inst_req, id_valid=1, id_adef=1, id_inst=0x03400000, id_pc=0x1c000002.
